// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the shared datapath: shift-add multiply (mode=0) or restoring divide (mode=1).
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic [WIDTH-1:0] step_hi,
    output logic [WIDTH-1:0] step_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        // Keep the bit shifted out of the remainder so the trial subtract never loses it.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        trial   = shifted - {1'b0, operand};
        if (mode) begin
            step_hi = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MULTU/DIVU (optionally MULT/DIV) unit owning HI/LO, one bit per cycle over a start/busy/done handshake.
// Define MULDIV_SIGNED_EN to make op 10/11 signed; otherwise they behave as 00/01.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] operand_reg, acc_hi_reg, acc_lo_reg, hi_reg, lo_reg;
    logic             mode_reg, neg_res_reg, neg_rem_reg, done_reg, div_zero_reg;

    logic [WIDTH-1:0] mag_a, mag_b, step_hi, step_lo, res_hi, res_lo;
    logic             neg_res, neg_rem, is_div, accept, zero_div, last;

`ifdef MULDIV_SIGNED_EN
    logic sign_a, sign_b;
    assign sign_a  = op[1] & dataA[WIDTH-1];
    assign sign_b  = op[1] & dataB[WIDTH-1];
    assign mag_a   = sign_a ? -dataA : dataA;
    assign mag_b   = sign_b ? -dataB : dataB;
    assign neg_res = sign_a ^ sign_b;
    assign neg_rem = sign_a;
`else
    assign mag_a   = dataA;
    assign mag_b   = dataB;
    assign neg_res = 1'b0;
    assign neg_rem = 1'b0;
`endif

    assign is_div   = (op == OP_DIVU) || (op == OP_DIV);
    assign accept   = (state_reg == IDLE) && start;
    assign zero_div = is_div && (dataB == '0);
    assign last     = (state_reg == RUN) && (cnt_reg == CW'(1));

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .mode    (mode_reg),
        .operand (operand_reg),
        .acc_hi  (acc_hi_reg),
        .acc_lo  (acc_lo_reg),
        .step_hi (step_hi),
        .step_lo (step_lo)
    );

    // Sign fix-up is applied on the final step so latency matches the unsigned path.
    always_comb begin
        res_hi = step_hi;
        res_lo = step_lo;
        if (mode_reg) begin
            if (neg_res_reg) res_lo = -step_lo;
            if (neg_rem_reg) res_hi = -step_hi;
        end else if (neg_res_reg) begin
            {res_hi, res_lo} = -{step_hi, step_lo};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && !zero_div) state_next = RUN;
            RUN:     if (cnt_reg == CW'(1))  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            operand_reg  <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            mode_reg     <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                div_zero_reg <= 1'b0;
                mode_reg     <= is_div;
                neg_res_reg  <= neg_res;
                neg_rem_reg  <= neg_rem;
                operand_reg  <= is_div ? mag_b : mag_a;
                acc_hi_reg   <= '0;
                acc_lo_reg   <= is_div ? mag_a : mag_b;
                cnt_reg      <= CW'(WIDTH);
                if (zero_div) begin
                    hi_reg       <= dataA;
                    lo_reg       <= '1;
                    div_zero_reg <= 1'b1;
                    done_reg     <= 1'b1;
                end
            end else if (state_reg == RUN) begin
                acc_hi_reg <= step_hi;
                acc_lo_reg <= step_lo;
                cnt_reg    <= cnt_reg - CW'(1);
                if (last) begin
                    hi_reg   <= res_hi;
                    lo_reg   <= res_lo;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy    = (state_reg == RUN);
    assign done    = done_reg;
    assign divZero = div_zero_reg;
    assign hi      = hi_reg;
    assign lo      = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] dataA = '0;
    logic [W-1:0] dataB = '0;
    logic         busy, done, divZero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .divZero (divZero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on magnitudes.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic edz, output int ew);
        logic sgn, na, nb;
        longint unsigned ma, mb, p, q, r;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = o[1];
`endif
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
        mb = nb ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
        if (!o[0]) begin
            p = ma * mb;
            if (na ^ nb) p = -p;
            eh = p[63:32]; el = p[31:0]; edz = 1'b0; ew = 32;
        end else if (b == 32'h0) begin
            eh = a; el = 32'hFFFF_FFFF; edz = 1'b1; ew = 0;
        end else begin
            q = ma / mb;
            r = ma % mb;
            if (na ^ nb) q = -q;
            if (na) r = -r;
            eh = r[31:0]; el = q[31:0]; edz = 1'b0; ew = 32;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; dataA = a; dataB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done (bounded), then checks latency, busy span and results; returns in the done cycle.
    task automatic finish_check(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                input logic exp_dz, input int exp_wait);
        int cycles = 0;
        int busy_cnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, cycles);
            return;
        end
        checks++;
        if (cycles !== exp_wait) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, cycles, exp_wait);
        end
        checks++;
        if (busy_cnt !== exp_wait) begin
            errors++;
            $display("FAIL %s_busy_span: got %0d busy cycles, required %0d", name, busy_cnt, exp_wait);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_in_done: got %b, required 0", name, busy);
        end
        checks++;
        if (hi !== exp_hi) begin
            errors++;
            $display("FAIL %s_hi: got %h, required %h", name, hi, exp_hi);
        end
        checks++;
        if (lo !== exp_lo) begin
            errors++;
            $display("FAIL %s_lo: got %h, required %h", name, lo, exp_lo);
        end
        checks++;
        if (divZero !== exp_dz) begin
            errors++;
            $display("FAIL %s_divZero: got %b, required %b", name, divZero, exp_dz);
        end
        $display("%s: hi=%h lo=%h divZero=%b latency=%0d", name, hi, lo, divZero, cycles);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, divZero, hi, lo} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, required all 0",
                     busy, done, divZero, hi, lo);
        end
        $display("reset: busy=%b done=%b divZero=%b hi=%h lo=%h", busy, done, divZero, hi, lo);
    endtask

    task automatic test_multu();
        @(negedge clk);
        launch(2'b00, 32'd7, 32'd6);
        finish_check("multu_7x6", 32'h0, 32'h2A, 1'b0, 32);
        @(negedge clk);
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_check("multu_max", 32'hFFFF_FFFE, 32'h1, 1'b0, 32);
    endtask

    task automatic test_divu();
        @(negedge clk);
        launch(2'b01, 32'd100, 32'd7);
        finish_check("divu_100_7", 32'd2, 32'd14, 1'b0, 32);
        @(negedge clk);
        launch(2'b01, 32'd5, 32'd0);
        finish_check("divu_by_zero", 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
        @(negedge clk);
        launch(2'b00, 32'd3, 32'd3);
        finish_check("dz_cleared", 32'd0, 32'd9, 1'b0, 32);
    endtask

    task automatic test_signed_ops();
`ifdef MULDIV_SIGNED_EN
        @(negedge clk);
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        finish_check("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
        @(negedge clk);
        launch(2'b10, 32'hFFFF_FFFD, 32'd4);
        finish_check("mult_neg3_4", 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, 32);
`else
        @(negedge clk);
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        finish_check("div_as_divu", 32'd1, 32'h7FFF_FFFC, 1'b0, 32);
        @(negedge clk);
        launch(2'b10, 32'hFFFF_FFFD, 32'd4);
        finish_check("mult_as_multu", 32'd3, 32'hFFFF_FFF4, 1'b0, 32);
`endif
    endtask

    task automatic test_ignored_start();
        logic [31:0] eh, el;
        logic edz;
        int ew;
        model(2'b00, 32'd1234, 32'd5678, eh, el, edz, ew);
        @(negedge clk);
        launch(2'b00, 32'd1234, 32'd5678);
        repeat (9) @(negedge clk);
        op = 2'b01; dataA = 32'd99; dataB = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_check("ignored_start", eh, el, edz, 22);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        logic edz;
        int ew;
        @(negedge clk);
        launch(2'b01, 32'd1000, 32'd3);
        finish_check("b2b_first", 32'd1, 32'd333, 1'b0, 32);
        for (int i = 0; i < 4; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom | 32'h1;
            b = $urandom | 32'h1;
            model(o, a, b, eh, el, edz, ew);
            launch(o, a, b);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy_after_done: got %b, required 1", busy);
            end
            finish_check($sformatf("b2b_%0d", i), eh, el, edz, ew);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] eh, el;
        logic edz;
        int ew;
        int done_seen = 0;
        @(negedge clk);
        launch(2'b00, 32'h0001_2345, 32'h0000_0777);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
        end
        $display("reset_midop: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL no_done_after_reset: got %0d done pulses, required 0", done_seen);
        end
        model(2'b00, 32'h0001_2345, 32'h0000_0777, eh, el, edz, ew);
        launch(2'b00, 32'h0001_2345, 32'h0000_0777);
        finish_check("after_reset", eh, el, edz, ew);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        logic edz;
        int ew;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            model(o, a, b, eh, el, edz, ew);
            @(negedge clk);
            launch(o, a, b);
            finish_check($sformatf("rand_%0d_op%0d", i, o), eh, el, edz, ew);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_divu();
        test_signed_ops();
        test_ignored_start();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle MULTU/DIVU execution unit beside the 32-bit combinational ALU in the EX stage; owns the HI/LO architectural registers.
- Driven by the EX stage over a start/busy/done handshake. Pipeline control stalls on busy.
- MFHI/MFLO read hi/lo directly.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- WIDTH, 32, operand width; hi/lo each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only while idle
- op  input  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
- dataA  input  WIDTH  multiplicand / dividend
- dataB  input  WIDTH  multiplier / divisor
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, hi/lo just updated
- divZero  output  1  sticky flag: last DIV/DIVU had divisor 0
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - busy=0, done=0, divZero=0, hi=0, lo=0.
  - State=IDLE; all internal registers cleared.
- Reset mid-operation aborts immediately. No done pulse is produced; hi/lo are cleared.
- States and transitions:
  - IDLE -> RUN on start=1. Operands, op and the iteration counter (WIDTH) are latched.
  - RUN decrements the counter on each edge. At the edge where the counter reaches 0, go to IDLE, write hi/lo, set done=1 for that one cycle, and clear busy.
- Timing:
  - busy rises on the edge after start is accepted (the accept edge) and stays high for exactly WIDTH cycles.
  - done is high during the cycle after the WIDTH-th iteration edge.
- start while busy=1 is ignored: no queuing, no effect.
- start in the same cycle done=1 is accepted, since the unit is already IDLE. This gives back-to-back operation with no bubble.
- hi/lo hold their previous values throughout RUN; they update only at completion. Results are computed in internal accumulators.
- Multiply:
  - 2*WIDTH accumulator {acc_hi, acc_lo}; acc_lo is initialised to dataB.
  - Each cycle: if acc_lo[0]=1, add dataA to acc_hi with a WIDTH+1-bit sum to keep the carry; then logical right shift of the whole accumulator by 1, with the carry entering at the MSB.
  - Final result: hi=acc_hi, lo=acc_lo. Full 64-bit unsigned product, no overflow.
- Divide (restoring):
  - Remainder starts at 0; the quotient register starts at dataA.
  - Each cycle: shift {rem, quo} left by 1, then compute trial = rem - dataB with a WIDTH+1-bit result.
  - If trial is non-negative: rem = trial and quo[0] = 1. Otherwise quo[0] = 0.
  - Final result: hi=rem, lo=quo.
- Divisor 0 (DIV or DIVU):
  - No iteration; completes in 1 cycle: done asserts the cycle after the accept edge, and busy is never raised.
  - Result: hi=dataA, lo = all ones, divZero=1.
- divZero is cleared on the accept of any subsequent op.
- Without signed support, op 10/11 behave exactly as 00/01.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: op 10/11 are signed.
  - Operands are converted to magnitudes at accept, and the unsigned core is run.
  - Product is negated (2*WIDTH two's complement) when the signs differ.
  - Quotient is negated when the signs differ; remainder takes the dividend's sign.
  - Latency is unchanged; the sign fix-up is folded into the write of hi/lo.
- Undefined: the signed path is not compiled; op[1] is ignored.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULTU=2'b00, OP_DIVU=2'b01, OP_MULT=2'b10, OP_DIV=2'b11
  - state typedef {IDLE, RUN}
  - WIDTH default
- Sub-module muldiv_core: the datapath-only iteration step (add/shift or subtract/shift), selected by a mode bit. The top level holds the FSM, counter, operand latches and hi/lo.

Test Plan:
- MULTU 7*6: start at cycle 0 -> busy cycles 1..32; done in cycle 33 with hi=0x00000000, lo=0x0000002A.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2, divZero=0. Then DIVU 5/0 -> done in the next cycle, busy never 1, hi=5, lo=0xFFFFFFFF, divZero=1.
- start pulsed at cycle 10 of a running op with different operands -> ignored; the original result appears. A start in the done cycle -> accepted, and busy is 1 in the next cycle.
- rst asserted asynchronously at cycle 15 of a MULTU -> busy/done/hi/lo immediately 0; no done afterwards; a fresh op then completes correctly.
- With MULDIV_SIGNED_EN:
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - MULT -3*4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
- Without MULDIV_SIGNED_EN: DIV 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=1.
